scs8hd_a32o_arc_exerciser: RTL and testbench
============================================

# scs8hd_a32o_arc_exerciser

Self-checking stimulus sequencer for the scs8hd_a32o cell family, where X = (A1&A2&A3) | (B1&B2). It drives the cell inputs and reads X back. For each of the 10 timing arcs (A1..B2, rising and falling) it applies a sensitizing vector, toggles the pin under test, and compares the observed X against the expected value. It sits in the library characterization/silicon-bringup harness, in the same clock domain as the combinational cell under test.

## Interface
- SETTLE, default 2: cycles held after each input change before X_OBS is sampled; must be ≥1.
- ERR_W, default 4: width of the error counter.
- CLK  in  1  sole clock, rising edge.
- RESETB  in  1  synchronous, active-low reset.
- START  in  1  begin a run; sampled only in IDLE.
- X_OBS  in  1  X output of the cell under test; sampled directly, no synchronizer.
- A1, A2, A3, B1, B2  out  1 each  registered drive to the cell inputs.
- BUSY  out  1  high from the cycle after START until the FINISH cycle, inclusive.
- DONE  out  1  one-cycle pulse in FINISH.
- ARC_IDX  out  4  current arc, 0..9.
- ARC_FAIL  out  1  one-cycle pulse on any miscompare.
- ERR_CNT  out  ERR_W  saturating count of miscompares.
- PASS  out  1  registered in FINISH as (ERR_CNT==0); holds until the next START.

## Operation
- Arc order: idx = 2·pin + dir. Pin order is A1, A2, A3, B1, B2. dir 0 = rise (pin 0→1, X 0→1); dir 1 = fall (pin 1→0, X 1→0).
- Side inputs for an A-pin arc: the other two A pins = 1, B1 = B2 = 0.
- Side inputs for a B-pin arc: the other B pin = 1, A1 = A2 = A3 = 0.
- FSM states: IDLE, SETUP, PRE, LAUNCH, POST, FINISH.
- IDLE: all drives 0. START=1 clears ERR_CNT and PASS, sets ARC_IDX=0 and goes to SETUP.
- SETUP (SETTLE cycles): drive side inputs and the pin's initial value.
- PRE (1 cycle): compare X_OBS to the initial expected X.
- LAUNCH (SETTLE cycles): pin toggled, side inputs unchanged.
- POST (1 cycle): compare X_OBS to the final expected X. If idx<9, go to SETUP with idx+1; otherwise go to FINISH.
- FINISH (1 cycle): DONE=1 and PASS registered, then return to IDLE with drives 0.
- Miscompare: ARC_FAIL pulses in the compare cycle. ERR_CNT increments in the same cycle and saturates at 2^ERR_W−1.
- START while BUSY is ignored.

## Timing
- Reset values: all outputs 0, FSM in IDLE.
- RESETB low mid-run: on the next edge, all outputs are at reset values and the run is abandoned with no DONE.
- START sampled at edge 0. SETUP drives are visible after edge 1.
- Each arc takes 2·SETTLE+2 cycles. DONE is high after edge 1+10·(2·SETTLE+2); this is edge 61 for SETTLE=2.
- Drives change only on SETUP and LAUNCH entry; they are stable through PRE and POST.

## Configuration
- SCS8HD_EXER_CAPTURE_EN defined: adds output ports FAIL_VALID (1), FAIL_ARC (4) and FAIL_PHASE (1; 0=PRE, 1=POST).
  - These ports latch the first miscompare of a run.
  - They clear on START and reset.
  - Later failures do not overwrite them.
- SCS8HD_EXER_CAPTURE_EN undefined: these ports and their registers are absent. All other behaviour is identical.

## Structure
- Package scs8hd_exer_pkg holds:
  - the FSM state enum;
  - NUM_ARCS=10;
  - the pin-index enum;
  - the ARC_IDX width.
- Sub-module scs8hd_a32o_vecgen, purely combinational:
  - inputs: arc index and phase (0=initial, 1=final);
  - outputs: the 5-bit drive vector {A1,A2,A3,B1,B2} and the expected X.
- The top level holds the FSM, the settle counter, the error counter and the capture logic.

## Test plan
- Correct behavioural a32o model, SETTLE=2, START → DONE at edge 61, PASS=1, ERR_CNT=0, no ARC_FAIL.
- X_OBS stuck-at-0 → 10 ARC_FAIL pulses (rise POST and fall PRE of every arc), ERR_CNT=10, PASS=0. With capture: FAIL_ARC=0, FAIL_PHASE=1.
- Cell model with B2 disconnected (X=A-term|B1):
  - B2 arcs fail (B2 rise PRE, B2 fall POST), ERR_CNT=2;
  - capture: FAIL_ARC=8, FAIL_PHASE=0.
- ERR_W=2 with X_OBS stuck-at-1 → ERR_CNT saturates at 3; ARC_FAIL still pulses 10 times.
- RESETB low at edge 20 of a run → all outputs 0 at edge 21, BUSY=0, no DONE. A new START then completes a full 61-cycle run.
- Second START pulse at edge 30 during a run → ignored; DONE still at edge 61.

Source files
------------

// File: rtl/scs8hd_a32o_arc_exerciser_pkg.sv
// Shared types for the scs8hd_a32o arc exerciser:
// FSM states, pin order and arc indexing.
package scs8hd_exer_pkg;

  localparam int NUM_ARCS = 10;
  localparam int IDX_W    = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_PRE,
    S_LAUNCH,
    S_POST,
    S_FINISH
  } state_e;

  typedef enum logic [2:0] {
    PIN_A1,
    PIN_A2,
    PIN_A3,
    PIN_B1,
    PIN_B2
  } pin_e;

  // vector order is {A1,A2,A3,B1,B2}
  function automatic logic a32o(input logic [4:0] v);
    return (v[4] & v[3] & v[2]) | (v[1] & v[0]);
  endfunction

endpackage

// File: rtl/scs8hd_a32o_arc_exerciser_if.sv
// Cell-side and control signals of the arc exerciser.
// Capture ports exist only with SCS8HD_EXER_CAPTURE_EN.
interface scs8hd_a32o_arc_exerciser_if #(
  parameter int ERR_W = 4
);
  import scs8hd_exer_pkg::*;

  logic             START;
  logic             X_OBS;
  logic             A1;
  logic             A2;
  logic             A3;
  logic             B1;
  logic             B2;
  logic             BUSY;
  logic             DONE;
  logic [IDX_W-1:0] ARC_IDX;
  logic             ARC_FAIL;
  logic [ERR_W-1:0] ERR_CNT;
  logic             PASS;
`ifdef SCS8HD_EXER_CAPTURE_EN
  logic             FAIL_VALID;
  logic [IDX_W-1:0] FAIL_ARC;
  logic             FAIL_PHASE;

  modport master (
    input  START, X_OBS,
    output A1, A2, A3, B1, B2,
    output BUSY, DONE, ARC_IDX,
    output ARC_FAIL, ERR_CNT, PASS,
    output FAIL_VALID, FAIL_ARC,
    output FAIL_PHASE
  );

  modport slave (
    output START, X_OBS,
    input  A1, A2, A3, B1, B2,
    input  BUSY, DONE, ARC_IDX,
    input  ARC_FAIL, ERR_CNT, PASS,
    input  FAIL_VALID, FAIL_ARC,
    input  FAIL_PHASE
  );
`else
  modport master (
    input  START, X_OBS,
    output A1, A2, A3, B1, B2,
    output BUSY, DONE, ARC_IDX,
    output ARC_FAIL, ERR_CNT, PASS
  );

  modport slave (
    output START, X_OBS,
    input  A1, A2, A3, B1, B2,
    input  BUSY, DONE, ARC_IDX,
    input  ARC_FAIL, ERR_CNT, PASS
  );
`endif

endinterface

// File: rtl/scs8hd_a32o_arc_exerciser_vecgen.sv
// Sensitizing vector and expected X for one arc/phase.
// idx = 2*pin + dir; phase 0 = initial, 1 = final.
module scs8hd_a32o_vecgen
  import scs8hd_exer_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             phase_i,
  output logic [4:0]       vec_o,
  output logic             x_exp_o
);

  logic [2:0] pin;
  logic       pv;

  always_comb begin
    pin   = idx_i[3:1];
    pv    = phase_i ^ idx_i[0];
    vec_o = '0;
    unique case (1'b1)
      (pin == PIN_A1): vec_o = {pv, 1'b1, 1'b1, 2'b00};
      (pin == PIN_A2): vec_o = {1'b1, pv, 1'b1, 2'b00};
      (pin == PIN_A3): vec_o = {1'b1, 1'b1, pv, 2'b00};
      (pin == PIN_B1): vec_o = {3'b000, pv, 1'b1};
      (pin == PIN_B2): vec_o = {3'b000, 1'b1, pv};
      default:         vec_o = '0;
    endcase
    x_exp_o = a32o(vec_o);
  end

endmodule

// File: rtl/scs8hd_a32o_arc_exerciser.sv
// Arc exerciser top: FSM, settle counter, error counter.
// SCS8HD_EXER_CAPTURE_EN adds first-failure capture.
module scs8hd_a32o_arc_exerciser
  import scs8hd_exer_pkg::*;
#(
  parameter int SETTLE = 2,
  parameter int ERR_W  = 4
) (
  input logic CLK,
  input logic RESETB,
  scs8hd_a32o_arc_exerciser_if.master bus
);

  localparam int CW = (SETTLE < 2) ? 1 : $clog2(SETTLE);
  localparam logic [CW-1:0]    CNT_LAST = CW'(SETTLE - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_ARCS - 1);

  state_e           state_q;
  logic [CW-1:0]    cnt_q;
  logic [IDX_W-1:0] idx_q;
  logic [4:0]       drv_q;
  logic             busy_q;
  logic             done_q;
  logic             fail_q;
  logic [ERR_W-1:0] err_q;
  logic             pass_q;
`ifdef SCS8HD_EXER_CAPTURE_EN
  logic             cv_q;
  logic [IDX_W-1:0] carc_q;
  logic             cph_q;
`endif

  logic       phase;
  logic       drive;
  logic       cmp;
  logic [4:0] vec;
  logic       x_exp;

  assign phase = (state_q == S_LAUNCH) || (state_q == S_POST);
  assign cmp   = (state_q == S_PRE) || (state_q == S_POST);
  assign drive = (state_q == S_SETUP) || (state_q == S_PRE) || phase;

  scs8hd_a32o_vecgen u_vecgen (
    .idx_i   (idx_q),
    .phase_i (phase),
    .vec_o   (vec),
    .x_exp_o (x_exp)
  );

  // Outputs are registered from the current state, so they
  // trail state entry by one edge.
  always_ff @(posedge CLK) begin
    if (!RESETB) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      drv_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      fail_q  <= 1'b0;
      err_q   <= '0;
      pass_q  <= 1'b0;
`ifdef SCS8HD_EXER_CAPTURE_EN
      cv_q    <= 1'b0;
      carc_q  <= '0;
      cph_q   <= 1'b0;
`endif
    end else begin
      busy_q <= (state_q != S_IDLE);
      done_q <= 1'b0;
      fail_q <= 1'b0;
      drv_q  <= drive ? vec : 5'b0;
      if (cmp && (bus.X_OBS != x_exp)) begin
        fail_q <= 1'b1;
        if (err_q != ERR_MAX) err_q <= err_q + 1'b1;
`ifdef SCS8HD_EXER_CAPTURE_EN
        if (!cv_q) begin
          cv_q   <= 1'b1;
          carc_q <= idx_q;
          cph_q  <= (state_q == S_POST);
        end
`endif
      end
      unique case (state_q)
        S_IDLE: begin
          if (bus.START) begin
            state_q <= S_SETUP;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= '0;
            pass_q  <= 1'b0;
`ifdef SCS8HD_EXER_CAPTURE_EN
            cv_q    <= 1'b0;
            carc_q  <= '0;
            cph_q   <= 1'b0;
`endif
          end
        end
        S_SETUP: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_PRE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_PRE: state_q <= S_LAUNCH;
        S_LAUNCH: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= S_POST;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_POST: begin
          if (idx_q == IDX_LAST) begin
            state_q <= S_FINISH;
          end else begin
            idx_q   <= idx_q + 1'b1;
            state_q <= S_SETUP;
          end
        end
        S_FINISH: begin
          done_q  <= 1'b1;
          pass_q  <= (err_q == '0);
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.A1       = drv_q[4];
  assign bus.A2       = drv_q[3];
  assign bus.A3       = drv_q[2];
  assign bus.B1       = drv_q[1];
  assign bus.B2       = drv_q[0];
  assign bus.BUSY     = busy_q;
  assign bus.DONE     = done_q;
  assign bus.ARC_IDX  = idx_q;
  assign bus.ARC_FAIL = fail_q;
  assign bus.ERR_CNT  = err_q;
  assign bus.PASS     = pass_q;
`ifdef SCS8HD_EXER_CAPTURE_EN
  assign bus.FAIL_VALID = cv_q;
  assign bus.FAIL_ARC   = carc_q;
  assign bus.FAIL_PHASE = cph_q;
`endif

endmodule

// File: tb/tb_scs8hd_a32o_arc_exerciser.sv
// Directed bench: cell models on X_OBS, scoreboard of
// expected run results popped at DONE.
module tb_scs8hd_a32o_arc_exerciser;

  logic clk = 1'b0;
  logic rstb;
  logic start;
  int   mode;
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  scs8hd_a32o_arc_exerciser_if #(.ERR_W(4)) if1 ();
  scs8hd_a32o_arc_exerciser_if #(.ERR_W(2)) if2 ();

  scs8hd_a32o_arc_exerciser #(.SETTLE(2), .ERR_W(4)) u1 (
    .CLK    (clk),
    .RESETB (rstb),
    .bus    (if1)
  );

  scs8hd_a32o_arc_exerciser #(.SETTLE(2), .ERR_W(2)) u2 (
    .CLK    (clk),
    .RESETB (rstb),
    .bus    (if2)
  );

  logic [4:0] drv1;
  assign drv1 = {if1.A1, if1.A2, if1.A3, if1.B1, if1.B2};

  // 0 good cell, 1 stuck-at-0, 2 B2 disconnected
  assign if1.X_OBS = (mode == 0) ?
                     ((if1.A1 & if1.A2 & if1.A3) | (if1.B1 & if1.B2)) :
                     (mode == 1) ? 1'b0 :
                     ((if1.A1 & if1.A2 & if1.A3) | if1.B1);
  assign if1.START = start;
  assign if2.X_OBS = 1'b1;
  assign if2.START = start;

  typedef struct {
    int unsigned err;
    logic        pass;
    int unsigned fails;
    int unsigned done_n;
    logic        cv;
    logic [3:0]  carc;
    logic        cph;
  } exp_t;

  exp_t sb[$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input int m, input bit dup,
                     input int unsigned e_err, input logic e_pass,
                     input int unsigned e_fails, input logic e_cv,
                     input logic [3:0] e_carc, input logic e_cph);
    exp_t e;
    exp_t g;
    int   n;
    int   f1;
    int   f2;
    e.err = e_err; e.pass = e_pass; e.fails = e_fails;
    e.done_n = 61; e.cv = e_cv; e.carc = e_carc; e.cph = e_cph;
    sb.push_back(e);
    mode  = m;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0; f1 = 0; f2 = 0;
    while (1) begin
      @(posedge clk);
      #1 n++;
      if (dup && n == 29) start = 1'b1;
      if (dup && n == 30) start = 1'b0;
      if (if1.ARC_FAIL) f1++;
      if (if2.ARC_FAIL) f2++;
      if (m == 0 && n == 1) begin
        chk("busy_e1", if1.BUSY, 1);
        chk("drv_a1r_setup", drv1, 5'b01100);
        chk("idx_e1", if1.ARC_IDX, 0);
      end
      if (m == 0 && n == 4) chk("drv_a1r_launch", drv1, 5'b11100);
      if (m == 0 && n == 55) chk("drv_b2f_setup", drv1, 5'b00011);
      if (m == 0 && n == 58) begin
        chk("drv_b2f_launch", drv1, 5'b00010);
        chk("idx_e58", if1.ARC_IDX, 9);
      end
      if (if1.DONE) break;
      if (n >= 200) begin
        chk("done_timeout", n, 61);
        break;
      end
    end
    g = sb.pop_front();
    chk("done_edge", n, g.done_n);
    chk("busy_at_done", if1.BUSY, 1);
    chk("err_cnt", if1.ERR_CNT, g.err);
    chk("pass", if1.PASS, g.pass);
    chk("arc_fail_pulses", f1, g.fails);
    chk("w2_err_sat", if2.ERR_CNT, 3);
    chk("w2_fail_pulses", f2, 10);
    chk("w2_pass", if2.PASS, 0);
`ifdef SCS8HD_EXER_CAPTURE_EN
    chk("cap_valid", if1.FAIL_VALID, g.cv);
    chk("cap_arc", if1.FAIL_ARC, g.carc);
    chk("cap_phase", if1.FAIL_PHASE, g.cph);
`endif
    @(posedge clk);
    #1;
    chk("busy_after", if1.BUSY, 0);
    chk("done_after", if1.DONE, 0);
    chk("pass_hold", if1.PASS, g.pass);
  endtask

  initial begin
    int n;
    int dn;
    rstb  = 1'b0;
    start = 1'b0;
    mode  = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", if1.BUSY, 0);
    chk("rst_done", if1.DONE, 0);
    chk("rst_drv", drv1, 0);
    chk("rst_idx", if1.ARC_IDX, 0);
    chk("rst_err", if1.ERR_CNT, 0);
    chk("rst_pass", if1.PASS, 0);
    chk("rst_fail", if1.ARC_FAIL, 0);
    rstb = 1'b1;
    @(posedge clk);
    #1;

    run(0, 1'b0, 0, 1'b1, 0, 1'b0, 4'd0, 1'b0);
    run(1, 1'b0, 10, 1'b0, 10, 1'b1, 4'd0, 1'b1);
    run(2, 1'b0, 2, 1'b0, 2, 1'b1, 4'd8, 1'b0);

    // abort a stuck-at-0 run with reset sampled at edge 20
    mode  = 1;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    chk("pre_rst_err", if1.ERR_CNT, 3);
    chk("pre_rst_busy", if1.BUSY, 1);
    rstb = 1'b0;
    @(posedge clk);
    #1;
    chk("abort_busy", if1.BUSY, 0);
    chk("abort_drv", drv1, 0);
    chk("abort_err", if1.ERR_CNT, 0);
    chk("abort_idx", if1.ARC_IDX, 0);
    chk("abort_done", if1.DONE, 0);
    @(posedge clk);
    #1 rstb = 1'b1;
    dn = 0;
    for (n = 0; n < 70; n++) begin
      @(posedge clk);
      #1 if (if1.DONE) dn++;
    end
    chk("abort_no_done", dn, 0);
    chk("abort_idle_busy", if1.BUSY, 0);

    run(0, 1'b1, 0, 1'b1, 0, 1'b0, 4'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
